// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: start detection, per-bit edge/bit counting,
// one-cycle strobes to the sampler/deserializer/checkers and frame qualification.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] Prescale,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic [5:0] edge_count,
    output logic [3:0] bit_count,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       busy
);

    localparam logic [3:0] LP_DW = 4'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [5:0] r_edge_cnt;
    logic [3:0] r_bit_cnt;
    logic [5:0] r_presc;
    logic       r_par_en;
    logic       r_par_flag;
    logic       r_data_valid;
    logic       r_parity_error;
    logic       r_framing_error;

    logic [5:0] w_presc_in;
    logic       w_bit_end;
    logic       w_start_entry;
    logic       w_frame_done;
    logic       w_deser_en;
    logic       w_strt_chk_en;
    logic       w_par_chk_en;
    logic       w_stp_chk_en;

    // Ratios below 4 leave too few edges for a mid-bit sample, so clamp.
    assign w_presc_in    = (Prescale < 6'd4) ? 6'd4 : Prescale;
    assign w_bit_end     = (r_edge_cnt == (r_presc - 6'd1));
    assign w_start_entry = (r_state != S_START) && (w_state_nxt == S_START);
    assign w_frame_done  = (r_state == S_STOP) && w_bit_end;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_deser_en    = 1'b0;
        w_strt_chk_en = 1'b0;
        w_par_chk_en  = 1'b0;
        w_stp_chk_en  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!RX_IN) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_strt_chk_en = 1'b1;
                    w_state_nxt   = strt_glitch ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_deser_en = 1'b1;
                    if (r_bit_cnt == LP_DW) w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_par_chk_en = 1'b1;
                    w_state_nxt  = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_stp_chk_en = 1'b1;
                    // A low line at stop end is the next start bit: go straight in.
                    w_state_nxt  = RX_IN ? S_IDLE : S_START;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_edge_cnt <= 6'd0;
            r_bit_cnt  <= 4'd0;
        end else if ((r_state == S_IDLE) || (w_state_nxt == S_IDLE)) begin
            r_edge_cnt <= 6'd0;
            r_bit_cnt  <= 4'd0;
        end else if (w_bit_end) begin
            r_edge_cnt <= 6'd0;
            r_bit_cnt  <= (r_state == S_STOP) ? 4'd0 : r_bit_cnt + 4'd1;
        end else begin
            r_edge_cnt <= r_edge_cnt + 6'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_presc  <= 6'd0;
            r_par_en <= 1'b0;
        end else if (w_start_entry) begin
            r_presc  <= w_presc_in;
            r_par_en <= PAR_EN;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_par_flag <= 1'b0;
        end else if (w_start_entry) begin
            r_par_flag <= 1'b0;
        end else if (w_par_chk_en && par_err) begin
            r_par_flag <= 1'b1;
        end
    end

    // Stop result is taken straight from the checker in the stop bit-end cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_data_valid    <= 1'b0;
            r_parity_error  <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            r_data_valid    <= w_frame_done && !r_par_flag && !stp_err;
            r_parity_error  <= w_frame_done && r_par_flag;
            r_framing_error <= w_frame_done && stp_err;
        end
    end

    assign edge_count    = r_edge_cnt;
    assign bit_count     = r_bit_cnt;
    assign dat_samp_en   = (r_state != S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign deser_en      = w_deser_en;
    assign strt_chk_en   = w_strt_chk_en;
    assign par_chk_en    = w_par_chk_en;
    assign stp_chk_en    = w_stp_chk_en;
    assign data_valid    = r_data_valid;
    assign parity_error  = r_parity_error;
    assign framing_error = r_framing_error;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: expected strobe/pulse events are queued when
// a frame is launched and matched cycle-by-cycle as the controller emits them.
module tb_uart_rx_ctrl;

    localparam int DW = 8;
    localparam logic [6:0] M_DESER = 7'h40;
    localparam logic [6:0] M_STRT  = 7'h20;
    localparam logic [6:0] M_PAR   = 7'h10;
    localparam logic [6:0] M_STP   = 7'h08;
    localparam logic [6:0] M_DV    = 7'h04;
    localparam logic [6:0] M_PE    = 7'h02;
    localparam logic [6:0] M_FE    = 7'h01;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] Prescale;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic [5:0] edge_count;
    logic [3:0] bit_count;
    logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic       data_valid, parity_error, framing_error, busy;

    typedef struct {
        int         cyc;
        logic [6:0] mask;
        logic [5:0] ec;
        logic [3:0] bc;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .edge_count(edge_count), .bit_count(bit_count), .dat_samp_en(dat_samp_en),
        .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
        .stp_chk_en(stp_chk_en), .data_valid(data_valid), .parity_error(parity_error),
        .framing_error(framing_error), .busy(busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input logic [6:0] m, input int ec, input int bc,
                           input int lim);
        ev_t e;
        if (lim != 0 && c >= lim) return;
        e.cyc = c; e.mask = m; e.ec = 6'(ec); e.bc = 4'(bc);
        sb.push_back(e);
    endtask

    // Every cycle with any strobe or result pulse must match the head of the queue.
    always @(negedge CLK) begin
        logic [6:0] m;
        ev_t e;
        m = {deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, parity_error, framing_error};
        if (m != 7'd0) begin
            if (sb.size() == 0) begin
                check("unexpected strobe", 32'(m), 32'd0);
            end else begin
                e = sb.pop_front();
                check("strobe mask", 32'(m), 32'(e.mask));
                check("strobe cycle", 32'(cyc), 32'(e.cyc));
                check("edge_count at strobe", 32'(edge_count), 32'(e.ec));
                check("bit_count at strobe", 32'(bit_count), 32'(e.bc));
            end
        end
    end

    task automatic start_idle();
        RX_IN = 1'b0;
        @(posedge CLK); #1;
    endtask

    // Called in the first START cycle; drives the serial line for the whole frame.
    task automatic run_frame(input int p, input bit par, input logic [7:0] data,
                             input bit perr, input bit serr, input bit b2b,
                             input int abort_at, input int chg_at, input logic [5:0] chg_val);
        int t0, n, lim, b;
        logic v;
        logic [6:0] res;
        t0  = cyc;
        n   = (2 + DW + (par ? 1 : 0)) * p;
        lim = (abort_at != 0) ? t0 + abort_at : 0;
        strt_glitch = 1'b0; par_err = perr; stp_err = serr;
        push_ev(t0 + p - 1, M_STRT, p - 1, 0, lim);
        for (int i = 0; i < DW; i++) push_ev(t0 + (i + 2) * p - 1, M_DESER, p - 1, i + 1, lim);
        if (par) push_ev(t0 + (DW + 2) * p - 1, M_PAR, p - 1, DW + 1, lim);
        push_ev(t0 + n - 1, M_STP, p - 1, DW + 1 + (par ? 1 : 0), lim);
        res = ((par && perr) || serr) ? ({6'd0, serr} | ((par && perr) ? M_PE : 7'd0)) : M_DV;
        push_ev(t0 + n, res, 0, 0, lim);
        check("busy in frame", 32'(busy), 32'd1);
        check("dat_samp_en in frame", 32'(dat_samp_en), 32'd1);
        for (int k = 0; k < n; k++) begin
            if (abort_at != 0 && k == abort_at) begin
                RST = 1'b0;
                #1;
                check("outputs after async reset",
                      32'({busy, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
                           data_valid, parity_error, framing_error}), 32'd0);
                check("counters after async reset", 32'({edge_count, bit_count}), 32'd0);
                RX_IN = 1'b1;
                repeat (2) begin @(posedge CLK); #1; end
                RST = 1'b1;
                repeat (3) begin @(posedge CLK); #1; end
                check("busy after reset abort", 32'(busy), 32'd0);
                check("queue drained after abort", 32'(sb.size()), 32'd0);
                return;
            end
            if (chg_at != 0 && k == chg_at) Prescale = chg_val;
            b = k / p;
            if (b == 0) v = 1'b0;
            else if (b <= DW) v = data[b-1];
            else if (par && b == DW + 1) v = ^data;
            else v = 1'b1;
            if (b2b && k == n - 1) v = 1'b0;
            RX_IN = v;
            @(posedge CLK); #1;
        end
        if (!b2b) begin
            check("busy after frame", 32'(busy), 32'd0);
            @(negedge CLK); #1;
            check("queue drained after frame", 32'(sb.size()), 32'd0);
        end
    endtask

    initial begin
        int t0;
        RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd8;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        #2;
        check("reset outputs",
              32'({busy, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
                   data_valid, parity_error, framing_error}), 32'd0);
        check("reset counters", 32'({edge_count, bit_count}), 32'd0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        repeat (3) begin @(posedge CLK); #1; end
        check("idle counters", 32'({edge_count, bit_count}), 32'd0);

        // P=8 with parity, clean frame
        Prescale = 6'd8; PAR_EN = 1'b1;
        start_idle();
        run_frame(8, 1, 8'hA5, 0, 0, 0, 0, 0, 6'd0);

        // P=16 no parity; par_err ignored without a parity bit
        Prescale = 6'd16; PAR_EN = 1'b0;
        start_idle();
        run_frame(16, 0, 8'h3C, 1, 0, 0, 0, 0, 6'd0);

        // start glitch abort
        Prescale = 6'd8; PAR_EN = 1'b1; strt_glitch = 1'b1;
        RX_IN = 1'b0;
        @(posedge CLK); #1;
        t0 = cyc;
        push_ev(t0 + 7, M_STRT, 7, 0, 0);
        @(posedge CLK); #1;
        RX_IN = 1'b1;
        repeat (7) begin @(posedge CLK); #1; end
        check("busy after glitch", 32'(busy), 32'd0);
        check("counters after glitch", 32'({edge_count, bit_count}), 32'd0);
        strt_glitch = 1'b0;
        repeat (20) begin @(posedge CLK); #1; end
        check("queue drained after glitch", 32'(sb.size()), 32'd0);

        // parity and stop errors together
        start_idle();
        run_frame(8, 1, 8'h96, 1, 1, 0, 0, 0, 6'd0);

        // back-to-back: first frame parity error, second clean (sticky flag cleared)
        start_idle();
        run_frame(8, 1, 8'h12, 1, 0, 1, 0, 0, 6'd0);
        run_frame(8, 1, 8'hED, 0, 0, 0, 0, 0, 6'd0);

        // reset mid-DATA
        start_idle();
        run_frame(8, 1, 8'h5A, 0, 0, 0, 40, 0, 6'd0);

        // Prescale changed mid-frame: current frame keeps 8, next uses 32
        Prescale = 6'd8; PAR_EN = 1'b0;
        start_idle();
        run_frame(8, 0, 8'hC3, 0, 0, 0, 0, 30, 6'd32);
        start_idle();
        run_frame(32, 0, 8'h81, 0, 0, 0, 0, 0, 6'd0);

        // Prescale below 4 clamps to 4; stop error only
        Prescale = 6'd2; PAR_EN = 1'b1;
        start_idle();
        run_frame(4, 1, 8'hFF, 0, 1, 0, 0, 0, 6'd0);

        repeat (5) begin @(posedge CLK); #1; end
        check("final queue empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Frame-sequencing FSM for the UART receive path.
- Detects the start edge on RX_IN and runs the per-bit edge counter and frame bit counter.
- Issues one-cycle enables to the data sampler, deserializer and start/parity/stop checkers.
- Qualifies each completed frame with a data_valid pulse or an error pulse. Sits between the RX pin synchroniser and the RX datapath (sampler, deserializer, checkers).

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5..12.

Ports:
- CLK  input  1  receive oversampling clock
- RST  input  1  asynchronous active-low reset
- RX_IN  input  1  synchronised serial line, idle high
- PAR_EN  input  1  1 = frame carries a parity bit
- Prescale  input  6  oversampling ratio, edges per bit
- strt_glitch  input  1  start checker result, combinational, valid while strt_chk_en=1
- par_err  input  1  parity checker result, valid while par_chk_en=1
- stp_err  input  1  stop checker result, valid while stp_chk_en=1
- edge_count  output  6  edge index within current bit, 0..Prescale-1
- bit_count  output  4  bit index within frame: start=0, data=1..DATA_WIDTH, parity=DATA_WIDTH+1, stop=last
- dat_samp_en  output  1  data sampler enable
- deser_en  output  1  one-cycle shift strobe to the deserializer
- strt_chk_en  output  1  one-cycle start check strobe
- par_chk_en  output  1  one-cycle parity check strobe
- stp_chk_en  output  1  one-cycle stop check strobe
- data_valid  output  1  registered one-cycle pulse: frame good
- parity_error  output  1  registered one-cycle pulse: frame failed parity
- framing_error  output  1  registered one-cycle pulse: frame failed stop check
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE; edge_count=0, bit_count=0; all enables, pulses and busy=0; shadow config cleared.
- States: IDLE, START, DATA, PARITY, STOP.
- Config latch: Prescale and PAR_EN are latched into shadow registers on every entry to START.
  - Prescale<4 latches as 4.
  - Input changes mid-frame have no effect.
  - P = latched prescale.
- Bit end: edge_count==P-1.
  - edge_count increments every cycle outside IDLE and wraps to 0 at bit end.
  - bit_count increments at each bit end.
- IDLE:
  - Counters held at 0.
  - RX_IN==0 → START. The first START cycle has edge_count=0.
- START:
  - At bit end: strt_chk_en=1.
  - strt_glitch=1 → IDLE, counters cleared.
  - strt_glitch=0 → DATA, bit_count=1.
- DATA:
  - deser_en=1 at each bit end, exactly DATA_WIDTH strobes per frame.
  - At bit end with bit_count==DATA_WIDTH → PARITY if shadow PAR_EN=1, else STOP.
- PARITY:
  - At bit end: par_chk_en=1, and par_err is captured into a sticky flag.
  - Then → STOP.
- STOP:
  - At bit end: stp_chk_en=1, and stp_err is captured.
  - Next state is START if RX_IN==0 in that cycle (back-to-back frame, no idle gap lost), else IDLE.
- Frame result, registered and appearing the cycle after stop bit end:
  - data_valid=1 iff no parity error and no stop error.
  - parity_error and framing_error pulse per their flag.
  - Both error pulses may assert together.
  - data_valid and error pulses are mutually exclusive.
  - Sticky flags clear on entry to START.
- dat_samp_en=1 in START, DATA, PARITY, STOP; 0 in IDLE.
- Enable timing: all *_en strobes are combinational from state and counters. At most one check/deser strobe is high per cycle.
- Glitch abort: produces no data_valid or error pulse.
- Reset mid-frame: abort immediately to IDLE with no pulses. The deserializer is not re-aligned by this block.
- Frame length: (2 + DATA_WIDTH + PAR_EN) × P cycles, START first cycle to STOP bit end inclusive.

Test Plan:
- P=8, PAR_EN=1, byte 0xA5, even parity correct, stop=1 (first START cycle = T0).
  - deser_en at T0+15, +23, …, +71.
  - par_chk_en at T0+79, stp_chk_en at T0+87.
  - data_valid=1 at T0+88; busy falls at T0+88.
- P=16, PAR_EN=0, 0x3C → 8 deser_en strobes spaced 16 cycles, stp_chk_en at T0+159, data_valid at T0+160, no par_chk_en.
- RX_IN low 2 cycles, checker model drives strt_glitch=1 at T0+7 → IDLE at T0+8, no deser_en, no pulses, busy low.
- P=8, PAR_EN=1, par_err=1 and stp_err=1 → parity_error=1 and framing_error=1 at T0+88, data_valid=0.
- Two back-to-back frames with RX_IN=0 at STOP bit end → direct STOP→START, second frame T0'=T0+88, second data_valid at T0+176.
- RST low at T0+40 mid-DATA → all outputs 0 asynchronously; Prescale changed to 32 mid-frame in a separate run → current frame timing unchanged, next frame uses 32.
